// File: rtl/rv_pipe_pkg.sv
// Shared MEM/WB pipeline types: the result-select encoding, the payload bundle and the NOP word.
// The payload field widths below fix the datapath widths of every user of this package.
package rv_pipe_pkg;

    localparam int unsigned MW_XLEN       = 32;
    localparam int unsigned MW_REG_ADDR_W = 5;
    localparam int unsigned MW_ILEN       = 32;

    localparam logic [MW_ILEN-1:0] NOP_INSTR = 32'h0000_0033;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_CSR = 2'b11
    } result_src_e;

    typedef struct packed {
        logic                     reg_write;
        result_src_e              result_src;
        logic [MW_XLEN-1:0]       read_data;
        logic [MW_XLEN-1:0]       alu_result;
        logic [MW_REG_ADDR_W-1:0] rd;
        logic [MW_XLEN-1:0]       pc_plus4;
        logic [MW_ILEN-1:0]       instr;
        logic                     csr;
        logic [MW_XLEN-1:0]       tbman_rdata;
    } mw_payload_t;

    function automatic logic [MW_XLEN-1:0] select_result(input mw_payload_t p);
        unique case (p.result_src)
            RES_ALU: select_result = p.alu_result;
            RES_MEM: select_result = p.read_data;
            RES_PC4: select_result = p.pc_plus4;
            RES_CSR: select_result = p.tbman_rdata;
            default: select_result = p.alu_result;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry elastic stage: a main register feeding the output plus one skid register.
// in_ready_o is registered and depends only on whether the skid entry will be occupied.
module pipe_skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic [Width-1:0] main_data_q, main_data_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             accept, retire;

    assign accept = in_valid_i & ready_q;
    assign retire = main_valid_q & out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q || retire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = accept;
                if (accept) skid_data_d = in_data_i;
            end else begin
                main_valid_d = accept;
                if (accept) main_data_d = in_data_i;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
        // Data is left in place on flush; the valid bits alone mark the entries empty.
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule

// File: rtl/pipeline_mw_elastic.sv
// Elastic MEM/WB stage with write-back result mux. XLEN/REG_ADDR_W/ILEN must match rv_pipe_pkg.
// Optional MW_PERF_CNT_EN adds stall_cnt and flush_cnt outputs.
module pipeline_mw_elastic
    import rv_pipe_pkg::*;
#(
    parameter int unsigned     XLEN       = MW_XLEN,
    parameter int unsigned     REG_ADDR_W = MW_REG_ADDR_W,
    parameter int unsigned     ILEN       = MW_ILEN,
    parameter logic [ILEN-1:0] NOP_INSTR  = rv_pipe_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [XLEN-1:0]       ReadData,
    input  logic [XLEN-1:0]       ALUResultM,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [XLEN-1:0]       PC_plus4M,
    input  logic [ILEN-1:0]       InstrM,
    input  logic                  csrM,
    input  logic [XLEN-1:0]       tbman_rdataM,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [XLEN-1:0]       ReadDataW,
    output logic [XLEN-1:0]       ALUResultW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic [XLEN-1:0]       PC_plus4W,
    output logic [ILEN-1:0]       InstrW,
    output logic                  csrW,
    output logic [XLEN-1:0]       tbman_rdataW,
    output logic [XLEN-1:0]       ResultW
`ifdef MW_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    mw_payload_t in_pl, head_pl, w_pl;

    always_comb begin
        in_pl             = '0;
        in_pl.reg_write   = RegWriteM;
        in_pl.result_src  = result_src_e'(ResultSrcM);
        in_pl.read_data   = ReadData;
        in_pl.alu_result  = ALUResultM;
        in_pl.rd          = RdM;
        in_pl.pc_plus4    = PC_plus4M;
        in_pl.instr       = InstrM;
        in_pl.csr         = csrM;
        in_pl.tbman_rdata = tbman_rdataM;
    end

    pipe_skid_buf #(
        .Width($bits(mw_payload_t))
    ) u_skid (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .in_valid_i (m_valid),
        .in_ready_o (m_ready),
        .in_data_i  (in_pl),
        .out_valid_o(w_valid),
        .out_ready_i(w_ready),
        .out_data_o (head_pl)
    );

    // An empty main entry is presented as a NOP bubble so WB never sees stale fields.
    always_comb begin
        w_pl = head_pl;
        if (!w_valid) begin
            w_pl       = '0;
            w_pl.instr = NOP_INSTR;
        end
    end

    assign RegWriteW    = w_pl.reg_write;
    assign ResultSrcW   = w_pl.result_src;
    assign ReadDataW    = w_pl.read_data;
    assign ALUResultW   = w_pl.alu_result;
    assign RdW          = w_pl.rd;
    assign PC_plus4W    = w_pl.pc_plus4;
    assign InstrW       = w_pl.instr;
    assign csrW         = w_pl.csr;
    assign tbman_rdataW = w_pl.tbman_rdata;
    assign ResultW      = select_result(w_pl);

`ifdef MW_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        stalled;
    logic [1:0]  dropped;

    assign stalled = w_valid & ~w_ready;

    // Skid occupancy is exactly !m_ready; a retiring main beat is not counted as dropped.
    always_comb begin
        dropped     = 2'(stalled) + 2'(~m_ready) + 2'(m_valid);
        stall_cnt_d = stall_cnt_q + 32'(stalled);
        flush_cnt_d = flush ? flush_cnt_q + 32'(dropped) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_mw_elastic.sv
// Scoreboard bench for pipeline_mw_elastic: accepted beats queue expected W values, retired beats are
// compared in order. Counter checks run when MW_PERF_CNT_EN is defined.
module tb_pipeline_mw_elastic;

    localparam logic [31:0] NOP = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst, flush, m_valid, m_ready, RegWriteM, csrM, w_valid, w_ready;
    logic [1:0]  ResultSrcM, ResultSrcW;
    logic [31:0] ReadData, ALUResultM, PC_plus4M, InstrM, tbman_rdataM;
    logic [4:0]  RdM, RdW;
    logic        RegWriteW, csrW;
    logic [31:0] ReadDataW, ALUResultW, PC_plus4W, InstrW, tbman_rdataW, ResultW;
`ifdef MW_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipeline_mw_elastic dut (
        .clk(clk), .rst(rst), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ReadData(ReadData),
        .ALUResultM(ALUResultM), .RdM(RdM), .PC_plus4M(PC_plus4M), .InstrM(InstrM),
        .csrM(csrM), .tbman_rdataM(tbman_rdataM), .w_valid(w_valid), .w_ready(w_ready),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW), .RdW(RdW), .PC_plus4W(PC_plus4W), .InstrW(InstrW),
        .csrW(csrW), .tbman_rdataW(tbman_rdataW), .ResultW(ResultW)
`ifdef MW_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        csr;
        logic        rw;
        int          cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t cur_exp;
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    // One clock: sample at negedge, then return 1 time unit after the rising edge.
    task automatic tick();
        beat_t o;
        @(negedge clk);
        cyc++;
        if (w_valid && w_ready && !rst) begin
            o.instr = InstrW; o.res = ResultW; o.rd = RdW; o.csr = csrW; o.rw = RegWriteW;
            o.cyc = cyc;
            obs_q.push_back(o);
        end
        if (m_valid && m_ready && !rst && !flush) begin
            cur_exp.cyc = cyc;
            exp_q.push_back(cur_exp);
        end
        if (flush && !rst) begin
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] src, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic [31:0] tbd, input logic [31:0] instr,
                         input logic [4:0] rd, input logic csr, input logic rw);
        m_valid = 1'b1; ResultSrcM = src; ALUResultM = alu; ReadData = rdata; PC_plus4M = pc4;
        tbman_rdataM = tbd; InstrM = instr; RdM = rd; csrM = csr; RegWriteM = rw;
        cur_exp.instr = instr; cur_exp.rd = rd; cur_exp.csr = csr; cur_exp.rw = rw;
        case (src)
            2'b00:   cur_exp.res = alu;
            2'b01:   cur_exp.res = rdata;
            2'b10:   cur_exp.res = pc4;
            default: cur_exp.res = tbd;
        endcase
    endtask

    task automatic idle();
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; w_ready = 1'b0; m_valid = 1'b0; RegWriteM = 1'b0;
        ResultSrcM = 2'b00; ReadData = '0; ALUResultM = '0; RdM = '0; PC_plus4M = '0;
        InstrM = '0; csrM = 1'b0; tbman_rdataM = '0;
        tick();
        tick();
        total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL reset_w_valid got=%b want=0", w_valid); end
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL reset_m_ready got=%b want=1", m_ready); end
        total++; if (InstrW !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", InstrW, NOP); end
        total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b want=0", RegWriteW); end
        total++; if (ResultW !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", ResultW); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        w_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(2'b00, 32'(i), 32'hA5A5_0000, 32'h0, 32'h0, 32'h0000_0093 + 32'(i << 7),
                  5'(i), 1'b0, 1'b1);
            tick();
        end
        idle();
        repeat (3) tick();
        total++;
        if (obs_q.size() !== 4) begin
            bad++; $display("FAIL stream_count got=%0d want=4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i].res !== exp_q[i].res || obs_q[i].instr !== exp_q[i].instr ||
                obs_q[i].rd !== exp_q[i].rd || obs_q[i].rw !== exp_q[i].rw) begin
                bad++; $display("FAIL stream_beat%0d got=%h/%h want=%h/%h", i, obs_q[i].res,
                                obs_q[i].instr, exp_q[i].res, exp_q[i].instr);
            end
            total++;
            if (obs_q[i].cyc - exp_q[i].cyc !== 1) begin
                bad++; $display("FAIL stream_latency%0d got=%0d want=1", i,
                                obs_q[i].cyc - exp_q[i].cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_instr;
        w_ready = 1'b0;
        a_instr = 32'h00A0_0013;
        drive(2'b00, 32'h0000_00A1, 32'h0, 32'h0, 32'h0, a_instr, 5'd10, 1'b0, 1'b1);
        tick();
        drive(2'b00, 32'h0000_00B2, 32'h0, 32'h0, 32'h0, 32'h00B0_0013, 5'd11, 1'b0, 1'b0);
        tick();
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL b2b_m_ready got=%b want=0", m_ready); end
        total++; if (w_valid !== 1'b1) begin bad++; $display("FAIL b2b_w_valid got=%b want=1", w_valid); end
        drive(2'b00, 32'h0000_00C3, 32'h0, 32'h0, 32'h0, 32'h00C0_0013, 5'd12, 1'b0, 1'b1);
        repeat (2) tick();
        total++; if (exp_q.size() !== 2) begin bad++; $display("FAIL b2b_c_held got=%0d want=2", exp_q.size()); end
        total++; if (InstrW !== a_instr) begin bad++; $display("FAIL b2b_stable got=%h want=%h", InstrW, a_instr); end
        w_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() < 3; k++) tick();
        idle();
        total++; if (exp_q.size() !== 3) begin bad++; $display("FAIL b2b_c_accept got=%0d want=3", exp_q.size()); end
        repeat (4) tick();
        total++;
        if (obs_q.size() !== 3) begin
            bad++; $display("FAIL b2b_count got=%0d want=3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i].res !== exp_q[i].res || obs_q[i].instr !== exp_q[i].instr ||
                obs_q[i].rd !== exp_q[i].rd || obs_q[i].rw !== exp_q[i].rw) begin
                bad++; $display("FAIL b2b_beat%0d got=%h/%h want=%h/%h", i, obs_q[i].res,
                                obs_q[i].instr, exp_q[i].res, exp_q[i].instr);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_result_mux();
        logic [1:0] srcs [4];
        srcs[0] = 2'b01; srcs[1] = 2'b10; srcs[2] = 2'b11; srcs[3] = 2'b00;
        w_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(srcs[i], 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0000_0055,
                  32'h0000_2073 + 32'(i << 7), 5'(7 + 8 * i), (srcs[i] == 2'b11), i[0]);
            tick();
        end
        idle();
        repeat (3) tick();
        total++;
        if (obs_q.size() !== 4) begin
            bad++; $display("FAIL mux_count got=%0d want=4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i].res !== exp_q[i].res) begin
                bad++; $display("FAIL mux_result%0d got=%h want=%h", i, obs_q[i].res, exp_q[i].res);
            end
            total++;
            if (obs_q[i].rd !== exp_q[i].rd || obs_q[i].csr !== exp_q[i].csr ||
                obs_q[i].rw !== exp_q[i].rw) begin
                bad++; $display("FAIL mux_fields%0d got=%0d/%b/%b want=%0d/%b/%b", i, obs_q[i].rd,
                                obs_q[i].csr, obs_q[i].rw, exp_q[i].rd, exp_q[i].csr, exp_q[i].rw);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_flush();
`ifdef MW_PERF_CNT_EN
        logic [31:0] f0;
        f0 = flush_cnt;
`endif
        w_ready = 1'b0;
        drive(2'b00, 32'h11, 32'h0, 32'h0, 32'h0, 32'h0110_0013, 5'd1, 1'b0, 1'b1);
        tick();
        drive(2'b00, 32'h22, 32'h0, 32'h0, 32'h0, 32'h0220_0013, 5'd2, 1'b0, 1'b1);
        tick();
        drive(2'b00, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0330_0013, 5'd3, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL flush_w_valid got=%b want=0", w_valid); end
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL flush_m_ready got=%b want=1", m_ready); end
        total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL flush_regwrite got=%b want=0", RegWriteW); end
        total++; if (InstrW !== NOP) begin bad++; $display("FAIL flush_instr got=%h want=%h", InstrW, NOP); end
`ifdef MW_PERF_CNT_EN
        total++;
        if (flush_cnt - f0 !== 32'd3) begin
            bad++; $display("FAIL flush_cnt got=%0d want=3", flush_cnt - f0);
        end
`endif
        w_ready = 1'b1;
        repeat (3) tick();
        total++;
        if (obs_q.size() !== 0) begin
            bad++; $display("FAIL flush_leak got=%0d want=0", obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef MW_PERF_CNT_EN
    task automatic test_perf();
        logic [31:0] s0;
        s0 = stall_cnt;
        w_ready = 1'b0;
        drive(2'b00, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0770_0013, 5'd7, 1'b0, 1'b1);
        tick();
        idle();
        repeat (7) tick();
        total++;
        if (stall_cnt - s0 !== 32'd7) begin
            bad++; $display("FAIL stall_cnt got=%0d want=7", stall_cnt - s0);
        end
        w_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stall_clr got=%0d want=0", stall_cnt); end
        total++; if (flush_cnt !== 32'd0) begin bad++; $display("FAIL flush_clr got=%0d want=0", flush_cnt); end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_result_mux();
        test_flush();
`ifdef MW_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
